// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg
// Shared types and helpers for the APB scratch/config RAM.
//   state_e  : controller states (INIT sweep, IDLE, WAIT states, RESP)
//   err_e    : reason a captured transfer is rejected
//   lane_count / lane_lsb : byte lanes per data word and log2 of that count
package apb_mem_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_RANGE,
        ERR_ALIGN,
        ERR_PRIV
    } err_e;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int lane_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array
// MEM_DEPTH x DATA_WIDTH word storage, split into one array per byte lane so
// each lane has its own write enable.
//   clk   : clock
//   addr  : word index shared by the write and read ports
//   we    : per-byte write enables, committed on the rising clock edge
//   wdata : write data
//   rdata : combinational read of the word at addr
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int AW         = 8
) (
    input  logic                    clk,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = lane_count(DATA_WIDTH);

    for (genvar gi = 0; gi < LANES; gi++) begin : lane_g
        logic [7:0] lane_mem [MEM_DEPTH];

        always_ff @(posedge clk) begin
            if (we[gi]) begin
                lane_mem[addr] <= wdata[gi*8 +: 8];
            end
        end

        assign rdata[gi*8 +: 8] = lane_mem[addr];
    end

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
// APB4 completer in front of a word RAM. After reset the RAM is cleared by a
// one-word-per-cycle sweep; transfers then get WAIT_STATES wait cycles, byte
// strobes, a privileged-only low region and range/alignment error reporting.
//   clk, rst            : clock, asynchronous active-high reset
//   psel/penable/pwrite : APB control (penable is not needed to start a transfer)
//   paddr/pwdata/pstrb  : byte address, write data, byte strobes
//   pprot               : protection; bit 0 marks a privileged access
//   pready/prdata/pslverr : response, only meaningful while pready=1
//   init_done           : high once the clear sweep has finished
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2,
    parameter int PRIV_WORDS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    output logic                    init_done
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int LSB   = lane_lsb(DATA_WIDTH);
    localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e                  state_q, state_d;
    logic [AW-1:0]           init_cnt_q, init_cnt_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    init_done_q, init_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]        strb_q, strb_d;
    logic                    priv_q, priv_d;

    logic [ADDR_WIDTH-1:0]   word_idx;
    err_e                    err_cause;
    logic [AW-1:0]           mem_addr;
    logic [LANES-1:0]        mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    // Only the privileged bit of pprot matters, and a transfer is accepted on
    // psel alone so one started during the sweep can finish afterwards.
    logic unused_inputs;
    assign unused_inputs = ^{pprot[2:1], penable};

    assign word_idx = addr_q >> LSB;

    // Errors are judged on the captured setup, not on the live bus.
    always_comb begin
        err_cause = ERR_NONE;
        if (32'(word_idx) >= MEM_DEPTH) begin
            err_cause = ERR_RANGE;
        end else if ((addr_q & ADDR_WIDTH'(LANES - 1)) != '0) begin
            err_cause = ERR_ALIGN;
        end else if ((32'(word_idx) < PRIV_WORDS) && !priv_q) begin
            err_cause = ERR_PRIV;
        end
    end

    // The clear sweep and normal writes share the array's single write port.
    always_comb begin
        mem_addr  = word_idx[AW-1:0];
        mem_we    = '0;
        mem_wdata = wdata_q;
        if (state_q == INIT) begin
            mem_addr  = init_cnt_q;
            mem_we    = '1;
            mem_wdata = '0;
        end else if (state_q == RESP && write_q && err_cause == ERR_NONE) begin
            mem_we = strb_q;
        end
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .AW         (AW)
    ) u_array (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        init_done_d = init_done_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        priv_d      = priv_q;

        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (32'(init_cnt_q) == MEM_DEPTH - 1) begin
                    init_cnt_d  = '0;
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (psel) begin
                    addr_d     = paddr;
                    write_d    = pwrite;
                    wdata_d    = pwdata;
                    strb_d     = pstrb;
                    priv_d     = pprot[0];
                    wait_cnt_d = 4'(WAIT_STATES - 1);
                    state_d    = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            init_done_q <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            priv_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            init_done_q <= init_done_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            priv_q      <= priv_d;
        end
    end

    // Responses are decoded straight from the state register so that an
    // asynchronous reset clears them at once.
    assign pready    = (state_q == RESP);
    assign pslverr   = (state_q == RESP) && (err_cause != ERR_NONE);
    assign prdata    = ((state_q == RESP) && !write_q && (err_cause == ERR_NONE))
                       ? mem_rdata : '0;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel_a, psel_b, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready_a, pslverr_a, init_done_a;
    logic        pready_b, pslverr_b, init_done_b;
    logic [31:0] prdata_a, prdata_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    apb_mem_slave #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2), .PRIV_WORDS(4)
    ) dut_a (
        .clk(clk), .rst(rst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a), .init_done(init_done_a)
    );

    apb_mem_slave #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0), .PRIV_WORDS(4)
    ) dut_b (
        .clk(clk), .rst(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b), .init_done(init_done_b)
    );

    typedef struct {
        string       name;
        bit          wr;
        logic [31:0] rd;
        bit          err;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One complete APB transfer; the expected response is queued at setup and
    // compared when pready is seen. lat counts access-phase cycles (-1 = skip).
    task automatic xfer(input bit d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input string name,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
        exp_t        e;
        int          n;
        bit          got;
        logic [31:0] act_rd;
        logic        act_err;
        e.name = name; e.wr = wr; e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat;
        sb_q.push_back(e);
        @(posedge clk); #1;
        pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr; penable = 1'b0;
        if (d) psel_b = 1'b1; else psel_a = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if ((d ? pready_b : pready_a) === 1'b1) got = 1'b1;
        end
        e = sb_q.pop_front();
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: pready not seen after %0d cycles, required within 400", e.name, n);
        end else begin
            act_rd  = d ? prdata_b : prdata_a;
            act_err = d ? pslverr_b : pslverr_a;
            if (!e.wr) check32({e.name, "_rdata"}, act_rd, e.rd);
            check32({e.name, "_err"}, 32'(act_err), 32'(e.err));
            if (e.lat >= 0) check32({e.name, "_lat"}, n, e.lat);
            $display("[TB] %s dut=%0d %s addr=%03h wdata=%08h strb=%h prot=%0d -> prdata=%08h pslverr=%0d cycles=%0d",
                     e.name, d, wr ? "WR" : "RD", a, wd, st, pr, act_rd, act_err, n);
        end
        @(posedge clk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    endtask

    task automatic add_vec(input string name, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input logic [31:0] rd, input bit er);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = a; v.wdata = wd; v.strb = st; v.prot = pr;
        v.exp_rd = rd; v.exp_err = er;
        vecs.push_back(v);
    endtask

    initial begin
        int  n;
        bit  bad;

        add_vec("rd_init",      0, 12'h010, 32'h0,        4'hF, 3'd0, 32'h00000000, 0);
        add_vec("wr_full",      1, 12'h040, 32'hDEADBEEF, 4'hF, 3'd0, 32'h0,        0);
        add_vec("rd_full",      0, 12'h040, 32'h0,        4'h0, 3'd0, 32'hDEADBEEF, 0);
        add_vec("wr_part",      1, 12'h040, 32'h11223344, 4'h5, 3'd0, 32'h0,        0);
        add_vec("rd_part",      0, 12'h040, 32'h0,        4'hF, 3'd0, 32'hDE22BE44, 0);
        add_vec("wr_nostrb",    1, 12'h040, 32'hFFFFFFFF, 4'h0, 3'd0, 32'h0,        0);
        add_vec("rd_nostrb",    0, 12'h040, 32'h0,        4'hF, 3'd0, 32'hDE22BE44, 0);
        add_vec("rd_range",     0, 12'h400, 32'h0,        4'hF, 3'd0, 32'h00000000, 1);
        add_vec("wr_misalign",  1, 12'h042, 32'h55555555, 4'hF, 3'd0, 32'h0,        1);
        add_vec("rd_misalign",  0, 12'h040, 32'h0,        4'hF, 3'd0, 32'hDE22BE44, 0);
        add_vec("wr_priv_user", 1, 12'h008, 32'hAAAA5555, 4'hF, 3'd0, 32'h0,        1);
        add_vec("rd_priv_chk",  0, 12'h008, 32'h0,        4'hF, 3'd1, 32'h00000000, 0);
        add_vec("wr_priv_ok",   1, 12'h008, 32'hAAAA5555, 4'hF, 3'd1, 32'h0,        0);
        add_vec("rd_priv_ok",   0, 12'h008, 32'h0,        4'hF, 3'd1, 32'hAAAA5555, 0);
        add_vec("rd_priv_user", 0, 12'h008, 32'h0,        4'hF, 3'd0, 32'h00000000, 1);
        add_vec("rd_priv_edge", 0, 12'h00C, 32'h0,        4'hF, 3'd1, 32'h00000000, 0);
        add_vec("wr_last",      1, 12'h3FC, 32'h12345678, 4'hF, 3'd0, 32'h0,        0);
        add_vec("rd_last",      0, 12'h3FC, 32'h0,        4'hF, 3'd0, 32'h12345678, 0);

        rst = 1'b1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check32("rst_pready",    32'(pready_a),    32'd0);
        check32("rst_prdata",    prdata_a,         32'd0);
        check32("rst_pslverr",   32'(pslverr_a),   32'd0);
        check32("rst_init_done", 32'(init_done_a), 32'd0);

        // Init sweep length
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (init_done_a === 1'b1) break;
        end
        check32("init_cycles", n, 32'd256);
        check32("init_done_b", 32'(init_done_b), 32'd1);
        $display("[TB] init sweep finished after %0d cycles", n);

        // Table-driven transfers on the 2-wait-state instance
        foreach (vecs[i]) begin
            xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
                 vecs[i].name, vecs[i].exp_rd, vecs[i].exp_err, 3);
        end

        // Abort: psel dropped during WAIT
        @(posedge clk); #1;
        psel_a = 1'b1; pwrite = 1'b1; paddr = 12'h040; pwdata = 32'h0BADF00D;
        pstrb = 4'hF; pprot = 3'd0; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check32("abort_wait_pready", 32'(pready_a), 32'd0);
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (pready_a !== 1'b0) bad = 1'b1;
        end
        check32("abort_no_pready", 32'(bad), 32'd0);
        $display("[TB] abort WR addr=040 wdata=0BADF00D -> stray pready=%0d", bad);
        xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'hF, 3'd0, "rd_after_abort", 32'hDE22BE44, 1'b0, 3);

        // Reset asserted during WAIT
        @(posedge clk); #1;
        psel_a = 1'b1; pwrite = 1'b1; paddr = 12'h044; pwdata = 32'h5A5A5A5A;
        pstrb = 4'hF; pprot = 3'd0; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check32("midrst_pready",    32'(pready_a),    32'd0);
        check32("midrst_init_done", 32'(init_done_a), 32'd0);
        $display("[TB] reset during WAIT -> pready=%0d init_done=%0d", pready_a, init_done_a);
        psel_a = 1'b0; penable = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Transfer issued during INIT completes WAIT_STATES+1 cycles after init_done
        repeat (5) @(posedge clk);
        xfer(1'b0, 1'b1, 12'h080, 32'hCAFEF00D, 4'hF, 3'd0, "wr_during_init", 32'h0, 1'b0, 253);
        xfer(1'b0, 1'b0, 12'h080, 32'h0, 4'hF, 3'd0, "rd_during_init", 32'hCAFEF00D, 1'b0, 3);
        xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'hF, 3'd0, "rd_cleared", 32'h00000000, 1'b0, 3);

        // Zero wait states
        xfer(1'b1, 1'b1, 12'h040, 32'hDEADBEEF, 4'hF, 3'd0, "ws0_wr", 32'h0, 1'b0, 1);
        xfer(1'b1, 1'b0, 12'h040, 32'h0, 4'hF, 3'd0, "ws0_rd", 32'hDEADBEEF, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
